// File: rtl/div_unit_pkg.sv
// Shared encodings for the B/C bus arithmetic units.
package div_unit_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FIX    = 2'd2;
    localparam logic [1:0] DONE_S = 2'd3;

    localparam logic DIV_QR_QUO = 1'b0;
    localparam logic DIV_QR_REM = 1'b1;

    localparam logic MUL_HILO_LO = 1'b0;
    localparam logic MUL_HILO_HI = 1'b1;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < divisor keeps shifted - divisor within WIDTH+1 signed bits
    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider on the B/C bus, START/BUSY/DONE handshake.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] B_In,
    input  logic [WIDTH-1:0] C,
    input  logic             U,
    input  logic             START,
    input  logic             DIV_QR,
    output logic [WIDTH-1:0] B_Out,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             sa;
    logic             sb;
    logic             dz;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             na;
    logic             nb;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign na = U & B_In[WIDTH-1];
    assign nb = U & C[WIDTH-1];

    // dvd shifts out dividend bits and shifts in quotient bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz    <= 1'b0;
            raw   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            prem  <= '0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE, DONE_S: begin
                    if (START) begin
                        sa    <= na;
                        sb    <= nb;
                        dvd   <= na ? -B_In : B_In;
                        dsr   <= nb ? -C : C;
                        dz    <= (C == '0);
                        raw   <= B_In;
                        prem  <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    prem <= step_rem;
                    dvd  <= {dvd[WIDTH-2:0], step_q};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quo <= '1;
                        rem <= raw;
                    end else begin
                        quo <= (sa ^ sb) ? -dvd : dvd;
                        rem <= sa ? -prem : prem;
                    end
                    state <= DONE_S;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        B_Out = quo;
        case (DIV_QR)
            DIV_QR_QUO: B_Out = quo;
            DIV_QR_REM: B_Out = rem;
        endcase
    end

    assign BUSY = (state == CALC) || (state == FIX);
    assign DONE = (state == DONE_S);

endmodule
